digit_entry_buffer: RTL and testbench

//   Parametrised successor to the keypad digit store. It collects keypad digits into an N-slot code,

---
 rtl/digit_entry_buffer.sv | 114 +++++++++++
 tb/tb_digit_entry_buffer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: keypad code collector with filtering, backspace, timeout and submit/ack handshake
module digit_entry_buffer #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_DIGIT      = 9,
  parameter int ALLOW_PARTIAL  = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          digit_valid,
  input  logic                          clear,
  input  logic                          backspace,
  input  logic                          submit,
  input  logic                          code_ack,
  output logic [NUM_DIGITS*DIGIT_W-1:0] code_out,
  output logic [NUM_DIGITS-1:0]         digits_to_display,
  output logic [$clog2(NUM_DIGITS+1)-1:0] count,
  output logic                          storage_full,
  output logic                          code_valid,
  output logic                          reject,
  output logic                          timeout
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic {ENTRY, PENDING} state_t;
  state_t state_q, state_d;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] slots_q, slots_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [NUM_DIGITS-1:0] disp_q, disp_d;
  logic full_q, full_d, reject_q, reject_d, timeout_q, timeout_d, accepted, expire;
  assign expire = TIMEOUT_CYCLES > 0 && count_q != '0 && timer_q == TLIM;
  // Next state: ENTRY edits by priority clear > submit > backspace > digit > inactivity; PENDING freezes the code
  always_comb begin
    state_d = state_q;
    slots_d = slots_q;
    count_d = count_q;
    reject_d = 1'b0;
    timeout_d = 1'b0;
    accepted = 1'b0;
    if (state_q == ENTRY) begin
      if (clear) begin
        slots_d = '0;
        count_d = '0;
        accepted = 1'b1;
      end else if (submit) begin
        if (full_q || (ALLOW_PARTIAL != 0 && count_q != '0)) state_d = PENDING;
        else reject_d = 1'b1;
      end else if (backspace) begin
        if (count_q != '0) begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (i == NUM_DIGITS - int'(count_q)) slots_d[i] = '0;
          count_d = count_q - CW'(1);
          accepted = 1'b1;
        end else reject_d = 1'b1;
      end else if (digit_valid) begin
        if (int'(digit_in) > MAX_DIGIT || full_q) reject_d = 1'b1;
        else begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (i == NUM_DIGITS - 1 - int'(count_q)) slots_d[i] = digit_in;
          count_d = count_q + CW'(1);
          accepted = 1'b1;
        end
      end else if (expire) begin
        slots_d = '0;
        count_d = '0;
        timeout_d = 1'b1;
      end
    end else begin
      if (clear || code_ack) begin
        slots_d = '0;
        count_d = '0;
        state_d = ENTRY;
      end else if (digit_valid || backspace || submit) reject_d = 1'b1;
    end
    for (int i = 0; i < NUM_DIGITS; i++) disp_d[i] = i >= NUM_DIGITS - int'(count_d);
    full_d = count_d == FULL;
    timer_d = (TIMEOUT_CYCLES == 0 || state_q != ENTRY || state_d != ENTRY || accepted ||
               count_d == '0 || timer_q == TLIM) ? '0 : timer_q + TW'(1);
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTRY;
      slots_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      disp_q <= '0;
      full_q <= 1'b0;
      reject_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slots_q <= slots_d;
      count_q <= count_d;
      timer_q <= timer_d;
      disp_q <= disp_d;
      full_q <= full_d;
      reject_q <= reject_d;
      timeout_q <= timeout_d;
    end
  end
  assign code_out = slots_q;
  assign digits_to_display = disp_q;
  assign count = count_q;
  assign storage_full = full_q;
  assign code_valid = state_q == PENDING;
  assign reject = reject_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_digit_entry_buffer.sv
// tb_digit_entry_buffer: directed checks of the default buffer and an 8-cycle-timeout variant
module tb_digit_entry_buffer;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] digit_in = '0;
  logic digit_valid = 1'b0, clear = 1'b0, backspace = 1'b0, submit = 1'b0, code_ack = 1'b0;
  logic [15:0] code_out, code_out_t;
  logic [3:0] disp, disp_t;
  logic [2:0] count, count_t;
  logic full, full_t, cv, cv_t, rej, rej_t, tmo, tmo_t;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  digit_entry_buffer dut (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid), .clear(clear),
    .backspace(backspace), .submit(submit), .code_ack(code_ack), .code_out(code_out),
    .digits_to_display(disp), .count(count), .storage_full(full), .code_valid(cv),
    .reject(rej), .timeout(tmo)
  );
  digit_entry_buffer #(.TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid), .clear(clear),
    .backspace(backspace), .submit(submit), .code_ack(code_ack), .code_out(code_out_t),
    .digits_to_display(disp_t), .count(count_t), .storage_full(full_t), .code_valid(cv_t),
    .reject(rej_t), .timeout(tmo_t)
  );
  task automatic step(input logic rs, input logic dv, input logic [3:0] d, input logic cl,
                      input logic bs, input logic sb, input logic ak);
    reset = rs; digit_valid = dv; digit_in = d; clear = cl; backspace = bs; submit = sb; code_ack = ak;
    @(negedge clk);
    reset = 1'b0; digit_valid = 1'b0; digit_in = '0; clear = 1'b0; backspace = 1'b0; submit = 1'b0; code_ack = 1'b0;
  endtask
  task automatic dig(input logic [3:0] d);
    step(0, 1, d, 0, 0, 0, 0);
  endtask
  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0, 0);
    total++; if (code_out !== 16'h0) begin bad++; $display("FAIL reset code_out got %h want 0000", code_out); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset count got %0d want 0", count); end
    total++; if ({disp, full, cv, rej, tmo} !== 8'h0) begin bad++; $display("FAIL reset flags got %b want 0", {disp, full, cv, rej, tmo}); end
  endtask
  task automatic test_fill;
    step(1, 0, 0, 0, 0, 0, 0);
    dig(1); dig(2);
    total++; if (disp !== 4'b1100) begin bad++; $display("FAIL fill2 disp got %b want 1100", disp); end
    dig(3); dig(4);
    total++; if (code_out !== 16'h1234) begin bad++; $display("FAIL fill code_out got %h want 1234", code_out); end
    total++; if ({disp, full, count} !== {4'b1111, 1'b1, 3'd4}) begin bad++; $display("FAIL fill disp/full/count got %b want 111114", {disp, full, count}); end
    dig(7);
    total++; if ({rej, code_out} !== {1'b1, 16'h1234}) begin bad++; $display("FAIL overflow rej/code got %b/%h want 1/1234", rej, code_out); end
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (rej !== 1'b0) begin bad++; $display("FAIL reject pulse width got %b want 0", rej); end
  endtask
  task automatic test_backspace;
    step(1, 0, 0, 0, 0, 0, 0);
    dig(5); dig(6);
    step(0, 0, 0, 0, 1, 0, 0);
    total++; if ({code_out, count, disp} !== {16'h5000, 3'd1, 4'b1000}) begin bad++; $display("FAIL bs1 got %h/%0d/%b want 5000/1/1000", code_out, count, disp); end
    step(0, 0, 0, 0, 1, 0, 0);
    total++; if ({count, rej} !== {3'd0, 1'b0}) begin bad++; $display("FAIL bs2 got count %0d rej %b want 0/0", count, rej); end
    step(0, 0, 0, 0, 1, 0, 0);
    total++; if ({count, rej} !== {3'd0, 1'b1}) begin bad++; $display("FAIL bs empty got count %0d rej %b want 0/1", count, rej); end
  endtask
  task automatic test_filter;
    step(1, 0, 0, 0, 0, 0, 0);
    dig(4'hB);
    total++; if ({rej, count} !== {1'b1, 3'd0}) begin bad++; $display("FAIL range got rej %b count %0d want 1/0", rej, count); end
    dig(9);
    total++; if ({rej, code_out} !== {1'b0, 16'h9000}) begin bad++; $display("FAIL max digit got rej %b code %h want 0/9000", rej, code_out); end
    dig(8); dig(7);
    step(0, 0, 0, 0, 0, 1, 0);
    total++; if ({rej, cv, count} !== {1'b1, 1'b0, 3'd3}) begin bad++; $display("FAIL partial submit got %b want 103", {rej, cv, count}); end
  endtask
  task automatic test_pending;
    dig(0);
    step(0, 0, 0, 0, 0, 1, 0);
    total++; if ({cv, rej, code_out} !== {1'b1, 1'b0, 16'h9870}) begin bad++; $display("FAIL submit got cv %b rej %b code %h want 1/0/9870", cv, rej, code_out); end
    dig(1);
    total++; if ({rej, cv, code_out} !== {1'b1, 1'b1, 16'h9870}) begin bad++; $display("FAIL pending digit got %b%b %h want 11 9870", rej, cv, code_out); end
    step(0, 0, 0, 0, 1, 0, 0);
    total++; if ({rej, count} !== {1'b1, 3'd4}) begin bad++; $display("FAIL pending bs got rej %b count %0d want 1/4", rej, count); end
    step(0, 0, 0, 0, 0, 0, 1);
    total++; if ({cv, count, code_out, disp, full} !== {1'b0, 3'd0, 16'h0, 4'b0, 1'b0}) begin bad++; $display("FAIL ack got cv %b count %0d code %h want 0/0/0000", cv, count, code_out); end
  endtask
  task automatic test_timeout;
    step(1, 0, 0, 0, 0, 0, 0);
    dig(3);
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      total++; if ({tmo_t, count_t} !== {1'b0, 3'd1}) begin bad++; $display("FAIL early timeout at %0d got tmo %b count %0d want 0/1", i, tmo_t, count_t); end
    end
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if ({tmo_t, count_t, code_out_t} !== {1'b1, 3'd0, 16'h0}) begin bad++; $display("FAIL timeout got tmo %b count %0d code %h want 1/0/0000", tmo_t, count_t, code_out_t); end
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL timeout disabled got %b want 0", tmo); end
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if (tmo_t !== 1'b0) begin bad++; $display("FAIL timeout pulse width got %b want 0", tmo_t); end
    dig(3);
    for (int i = 1; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0);
    dig(4);
    step(0, 0, 0, 0, 0, 0, 0);
    total++; if ({tmo_t, count_t, code_out_t} !== {1'b0, 3'd2, 16'h3400}) begin bad++; $display("FAIL timer restart got tmo %b count %0d code %h want 0/2/3400", tmo_t, count_t, code_out_t); end
  endtask
  task automatic test_reset_pending;
    step(1, 0, 0, 0, 0, 0, 0);
    dig(1); dig(2); dig(3); dig(4);
    step(0, 0, 0, 0, 0, 1, 0);
    total++; if (cv !== 1'b1) begin bad++; $display("FAIL pending entry got cv %b want 1", cv); end
    step(1, 1, 5, 0, 0, 1, 0);
    total++; if ({cv, count, code_out, disp, full, rej, tmo} !== 27'h0) begin bad++; $display("FAIL reset in pending got cv %b count %0d code %h", cv, count, code_out); end
    dig(2);
    step(0, 1, 5, 1, 0, 0, 0);
    total++; if ({count, rej, code_out} !== {3'd0, 1'b0, 16'h0}) begin bad++; $display("FAIL clear+digit got count %0d rej %b code %h want 0/0/0000", count, rej, code_out); end
  endtask
  task automatic test_back_to_back;
    step(1, 0, 0, 0, 0, 0, 0);
    dig(6);
    step(0, 1, 7, 0, 1, 0, 0);
    total++; if ({count, code_out, rej} !== {3'd0, 16'h0, 1'b0}) begin bad++; $display("FAIL bs beats digit got count %0d code %h rej %b want 0/0000/0", count, code_out, rej); end
    dig(2); dig(0); dig(2); dig(5);
    step(0, 1, 1, 0, 0, 1, 0);
    total++; if ({cv, rej, code_out} !== {1'b1, 1'b0, 16'h2025}) begin bad++; $display("FAIL submit beats digit got cv %b rej %b code %h want 1/0/2025", cv, rej, code_out); end
    step(0, 1, 1, 1, 0, 0, 1);
    total++; if ({cv, rej, count} !== {1'b0, 1'b0, 3'd0}) begin bad++; $display("FAIL pending clear got cv %b rej %b count %0d want 0/0/0", cv, rej, count); end
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_fill;
    test_backspace;
    test_filter;
    test_pending;
    test_timeout;
    test_reset_pending;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
